// File: rtl/baud_clock_gen.sv
// baud_clock_gen: per-channel 16x baud prescaler, 3-bit phase divider and falling-edge pulse stretcher.
// Optional macro BAUD_RESYNC_EN enables the per-channel resync input (count/phase realign).
module baud_clock_gen #(
    parameter int CLK_HZ       = 100000000,
    parameter int NCH          = 2,
    parameter int DIVW         = 16,
    parameter int PULSE_CYCLES = 9,
    parameter int DEFAULT_IDX  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic [4*NCH-1:0] rate_sel,
    input  logic [NCH-1:0]   strobe_in,
    input  logic [NCH-1:0]   resync,
    output logic [NCH-1:0]   tick16,
    output logic [3*NCH-1:0] phase,
    output logic [NCH-1:0]   pulse_out,
    output logic [NCH-1:0]   rate_busy
);
    typedef logic [15:0][DIVW-1:0] div_tab_t;
    localparam int BAUD [12] = '{110, 150, 300, 600, 1200, 2400, 4800, 9600,
                                 19200, 38400, 57600, 115200};

    function automatic longint div_of_baud(longint b);
        return (longint'(CLK_HZ) + 8 * b) / (16 * b) - 1;
    endfunction

    // Reserved indices 12..15 carry the default divisor so the table lookup needs no remap.
    function automatic div_tab_t calc_tab();
        div_tab_t t;
        for (int k = 0; k < 16; k++) t[k] = DIVW'(div_of_baud(longint'(BAUD[k < 12 ? k : DEFAULT_IDX])));
        return t;
    endfunction

    localparam div_tab_t DIV_TAB = calc_tab();

    if (div_of_baud(longint'(BAUD[0])) > (longint'(1) << DIVW) - 1) begin : g_div_overflow
        $error("baud_clock_gen: table divisor exceeds DIVW");
    end

`ifndef BAUD_RESYNC_EN
    logic unused_resync;
    assign unused_resync = ^resync;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIVW-1:0] cnt;
        logic [2:0]      ph;
        logic [3:0]      act, pend, sel, act_next;
        logic [3:0]      pc;
        logic            tc, rs, tick, busy, prev, fall;
        assign sel      = rate_sel[4*i+:4] > 4'd11 ? 4'(DEFAULT_IDX) : rate_sel[4*i+:4];
        assign tc       = en[i] && cnt >= DIV_TAB[act];
        assign act_next = !en[i] ? sel : (tc && !rs) ? pend : act;
        assign fall     = prev && !strobe_in[i];
`ifdef BAUD_RESYNC_EN
        assign rs = resync[i];
`else
        assign rs = 1'b0;
`endif
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt  <= '0;
                ph   <= '0;
                tick <= 1'b0;
                act  <= 4'(DEFAULT_IDX);
                pend <= 4'(DEFAULT_IDX);
                busy <= 1'b0;
                prev <= 1'b1;
                pc   <= '0;
            end else begin
                cnt  <= (rs || tc || !en[i]) ? '0 : cnt + DIVW'(1);
                ph   <= (rs || !en[i]) ? 3'd0 : ph + 3'(tc);
                tick <= tc && !rs;
                act  <= act_next;
                pend <= sel;
                busy <= en[i] && sel != act_next;
                prev <= strobe_in[i];
                pc   <= fall ? 4'd1 : (pc != 4'd0 && pc < 4'(PULSE_CYCLES)) ? pc + 4'd1 : 4'd0;
            end
        end
        assign tick16[i]       = tick;
        assign phase[3*i+:3]   = ph;
        assign pulse_out[i]    = pc != 4'd0;
        assign rate_busy[i]    = busy;
    end
endmodule
